riscv_id_instr_queue: RTL and testbench
=======================================

RISCV_ID_INSTR_QUEUE -- requirements
Module: riscv_id_instr_queue

Interface
REQ-001 The block SHALL use a single clock `clk` and an asynchronous, active-high reset `reset`; all state is cleared on `reset` rising, independent of `clk`.
REQ-002 Parameter DATA_WIDTH, default 64: PC width.
REQ-003 Parameter INSTR_WIDTH, default 32: instruction width.
REQ-004 Parameter DEPTH, default 4: queue entries; power of two, 2 to 16.
REQ-005 Parameter CW = $clog2(DEPTH)+1: occupancy width (derived, not overridable).
REQ-006 clk  in  1  clock.
REQ-007 reset  in  1  async active-high reset.
REQ-008 enable  in  1  global enable; 0 freezes all state.
REQ-009 i_flush  in  1  discard all queued entries.
REQ-010 i_valid  in  1  fetch offers an entry.
REQ-011 i_instr  in  INSTR_WIDTH  offered instruction.
REQ-012 i_pc  in  DATA_WIDTH  offered PC.
REQ-013 o_ready  out  1  queue accepts an entry this cycle.
REQ-014 o_valid  out  1  head entry available to decode.
REQ-015 i_ready  in  1  decode consumes head (driven as !stall).
REQ-016 o_instr  out  INSTR_WIDTH  head instruction.
REQ-017 o_pc  out  DATA_WIDTH  head PC.
REQ-018 o_rs1_addr / o_rs2_addr / o_rd_addr  out  5 each  head instr [19:15] / [24:20] / [11:7].
REQ-019 o_illegal  out  1  o_valid and head instr[1:0] != 2'b11.
REQ-020 o_count  out  CW  current occupancy, 0..DEPTH.
REQ-021 o_full / o_empty  out  1 each  o_count==DEPTH / o_count==0.
REQ-022 o_flushed  out  16  saturating total of entries discarded by flushes.

Function
REQ-023 Storage SHALL be DEPTH registers of {pc, instr}, with write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-024 o_ready SHALL be enable && !o_full && !i_flush; when full, a push is refused even if a pop occurs in the same cycle.
REQ-025 o_valid SHALL be enable && !o_empty && !i_flush.
REQ-026 Push SHALL occur on a clock edge where i_valid && o_ready; the entry is written at wptr and wptr increments.
REQ-027 Pop SHALL occur on a clock edge where o_valid && i_ready; rptr increments.
REQ-028 Simultaneous push and pop SHALL leave o_count unchanged and move both pointers.
REQ-029 Head outputs are first-word fall-through from storage at rptr; an entry pushed at edge N is visible at the outputs in cycle N+1, so latency is 1 cycle.
REQ-030 Head outputs SHALL hold stable while o_valid && !i_ready.
REQ-031 When o_valid=0, head outputs are don't-care, but o_illegal SHALL be 0.
REQ-032 i_flush SHALL take priority over push and pop: at the edge, pointers and o_count go to 0, and o_flushed += the pre-flush o_count, saturating at 16'hFFFF.
REQ-033 With enable=0, pointers, storage, o_count and o_flushed SHALL hold; i_flush is ignored.
REQ-034 Storage contents are not cleared by flush; only the pointers are reset.

Reset
REQ-035 While reset is high: o_count=0, o_empty=1, o_full=0, o_valid=0, o_ready=0, o_illegal=0, o_flushed=0, pointers=0.
REQ-036 Reset asserted mid-operation SHALL discard all entries without incrementing o_flushed.
REQ-037 After reset deasserts, o_ready=1 in the first cycle with enable=1; storage contents are undefined and are never exposed while o_empty=1.

Verification
REQ-038 Fill: push 4 entries (pc 0x100..0x10C, instr 0x00000013) with i_ready=0. Required: o_count 1→4, o_full=1, o_ready=0; a 5th push is refused and o_count stays 4.
REQ-039 Full with push+pop: with i_valid=1 and i_ready=1 in the same cycle, the pop is taken and the push refused. Required: o_count=3, o_pc=0x104 next cycle.
REQ-040 Streaming: i_valid=i_ready=1 for 20 cycles with incrementing PCs. Required: one output per cycle after the first, in order, across pointer wrap, with o_count steady at 1.
REQ-041 Flush: with 3 entries queued, pulse i_flush together with i_valid. Required: next cycle o_count=0, o_valid=0, o_flushed=3, and the concurrent entry is dropped.
REQ-042 Illegal and fields: push instr 0x00C58533. Required: rs1=11, rs2=12, rd=10, o_illegal=0. Then push 0x0000_4501. Required: o_illegal=1 when it reaches the head.
REQ-043 Async reset mid-stream: assert reset between clock edges with 2 entries queued. Required: outputs reach reset values immediately, and o_flushed stays 0.

Source files
------------

// File: rtl/riscv_id_instr_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, instr} with
// first-word fall-through head, flush with saturating discard count.
module riscv_id_instr_queue #(
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         i_flush,
    input  logic                         i_valid,
    input  logic [INSTR_WIDTH-1:0]       i_instr,
    input  logic [DATA_WIDTH-1:0]        i_pc,
    output logic                         o_ready,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [INSTR_WIDTH-1:0]       o_instr,
    output logic [DATA_WIDTH-1:0]        o_pc,
    output logic [4:0]                   o_rs1_addr,
    output logic [4:0]                   o_rs2_addr,
    output logic [4:0]                   o_rd_addr,
    output logic                         o_illegal,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [15:0]                  o_flushed
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [CW-1:0]          count;
    logic [15:0]            flushed;
    logic [16:0]            flush_sum;
    logic                   push;
    logic                   pop;

    assign o_count   = count;
    assign o_full    = (count == CW'(DEPTH));
    assign o_empty   = (count == '0);
    assign o_flushed = flushed;

    // reset gates o_ready so fetch never sees an accepting queue during reset
    assign o_ready = enable && !o_full && !i_flush && !reset;
    assign o_valid = enable && !o_empty && !i_flush;
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    assign o_instr    = instr_mem[rptr];
    assign o_pc       = pc_mem[rptr];
    assign o_rs1_addr = o_instr[19:15];
    assign o_rs2_addr = o_instr[24:20];
    assign o_rd_addr  = o_instr[11:7];
    assign o_illegal  = o_valid && (o_instr[1:0] != 2'b11);

    always_comb begin
        flush_sum = {1'b0, flushed} + 17'(count);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            flushed <= '0;
        end else if (enable) begin
            if (i_flush) begin
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                flushed <= flush_sum[16] ? '1 : flush_sum[15:0];
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // storage is deliberately not reset; entries are only exposed while non-empty
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr]    <= i_pc;
            instr_mem[wptr] <= i_instr;
        end
    end

endmodule

// File: tb/tb_riscv_id_instr_queue.sv
// Self-checking bench for riscv_id_instr_queue: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_riscv_id_instr_queue;

    localparam int DW = 64;
    localparam int IW = 32;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_valid = 1'b0;
    logic [IW-1:0] i_instr = '0;
    logic [DW-1:0] i_pc = '0;
    logic          i_ready = 1'b0;
    logic          o_ready, o_valid, o_illegal, o_full, o_empty;
    logic [IW-1:0] o_instr;
    logic [DW-1:0] o_pc;
    logic [4:0]    o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [CW-1:0] o_count;
    logic [15:0]   o_flushed;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model: queue of {pc, instr} and discard total
    logic [DW+IW-1:0] mq[$];
    int unsigned      mflush = 0;

    riscv_id_instr_queue #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .i_flush(i_flush),
        .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc), .o_ready(o_ready),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc),
        .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
        .o_illegal(o_illegal), .o_count(o_count), .o_full(o_full),
        .o_empty(o_empty), .o_flushed(o_flushed)
    );

    always #5 clk = ~clk;

    function automatic bit m_ready();
        return enable && !reset && !i_flush && (mq.size() < DEPTH);
    endfunction

    function automatic bit m_valid();
        return enable && !i_flush && (mq.size() > 0);
    endfunction

    // one clock edge with the model updated alongside; returns 1 ns after the edge
    task automatic cycle();
        bit do_push, do_pop;
        do_push = i_valid && m_ready();
        do_pop  = m_valid() && i_ready;
        @(posedge clk);
        if (enable && i_flush) begin
            mflush = (mflush + mq.size() > 65535) ? 65535 : mflush + mq.size();
            mq.delete();
        end else if (enable) begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({i_pc, i_instr});
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        mflush = 0;
        #3;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        #3;
        n_cmp++; if (o_count !== 0)  begin n_fail++; $display("FAIL reset_count got=%0d exp=0", o_count); end
        n_cmp++; if (o_empty !== 1)  begin n_fail++; $display("FAIL reset_empty got=%b exp=1", o_empty); end
        n_cmp++; if (o_full !== 0)   begin n_fail++; $display("FAIL reset_full got=%b exp=0", o_full); end
        n_cmp++; if (o_valid !== 0)  begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        n_cmp++; if (o_ready !== 0)  begin n_fail++; $display("FAIL reset_ready got=%b exp=0", o_ready); end
        n_cmp++; if (o_illegal !== 0) begin n_fail++; $display("FAIL reset_illegal got=%b exp=0", o_illegal); end
        n_cmp++; if (o_flushed !== 0) begin n_fail++; $display("FAIL reset_flushed got=%0d exp=0", o_flushed); end
        do_reset();
        n_cmp++; if (o_ready !== 1)  begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_fill();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_instr = 32'h0000_0013;
        for (int k = 0; k < 4; k++) begin
            i_pc = 64'h100 + 64'(4 * k);
            cycle();
            n_cmp++; if (o_count !== CW'(k + 1)) begin n_fail++; $display("FAIL fill_count k=%0d got=%0d exp=%0d", k, o_count, k + 1); end
        end
        n_cmp++; if (o_full !== 1)  begin n_fail++; $display("FAIL fill_full got=%b exp=1", o_full); end
        n_cmp++; if (o_ready !== 0) begin n_fail++; $display("FAIL fill_ready got=%b exp=0", o_ready); end
        i_pc = 64'h110;
        cycle();
        n_cmp++; if (o_count !== 4) begin n_fail++; $display("FAIL fill_fifth_count got=%0d exp=4", o_count); end
        n_cmp++; if (o_pc !== 64'h100) begin n_fail++; $display("FAIL fill_head_pc got=%h exp=100", o_pc); end
    endtask

    task automatic test_full_push_pop();
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_pc = 64'h200;
        cycle();
        i_valid = 1'b0;
        i_ready = 1'b0;
        n_cmp++; if (o_count !== 3)      begin n_fail++; $display("FAIL fullpp_count got=%0d exp=3", o_count); end
        n_cmp++; if (o_pc !== 64'h104)   begin n_fail++; $display("FAIL fullpp_pc got=%h exp=104", o_pc); end
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (o_pc !== 64'h104 + 64'(4 * k)) begin n_fail++; $display("FAIL drain_pc k=%0d got=%h exp=%h", k, o_pc, 64'h104 + 64'(4 * k)); end
            cycle();
        end
        i_ready = 1'b0;
        n_cmp++; if (o_empty !== 1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", o_empty); end
    endtask

    task automatic test_streaming();
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_instr = 32'h0000_0013;
        for (int k = 0; k < 20; k++) begin
            i_pc = 64'h1000 + 64'(4 * k);
            cycle();
            n_cmp++;
            if (o_count !== 1 || o_valid !== 1 || o_pc !== 64'h1000 + 64'(4 * k)) begin
                n_fail++;
                $display("FAIL stream k=%0d got count=%0d valid=%b pc=%h exp count=1 valid=1 pc=%h",
                         k, o_count, o_valid, o_pc, 64'h1000 + 64'(4 * k));
            end
        end
        i_valid = 1'b0;
        cycle();
        i_ready = 1'b0;
        n_cmp++; if (o_count !== 0) begin n_fail++; $display("FAIL stream_end_count got=%0d exp=0", o_count); end
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_pc = 64'h500 + 64'(4 * k);
            cycle();
        end
        i_pc = 64'h50C;
        i_flush = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 0 || o_valid !== 0) begin n_fail++; $display("FAIL flush_comb got ready=%b valid=%b exp 0 0", o_ready, o_valid); end
        cycle();
        i_flush = 1'b0;
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_count !== 0)  begin n_fail++; $display("FAIL flush_count got=%0d exp=0", o_count); end
        n_cmp++; if (o_valid !== 0)  begin n_fail++; $display("FAIL flush_valid got=%b exp=0", o_valid); end
        n_cmp++; if (o_flushed !== 16'(mflush) || mflush != 3) begin n_fail++; $display("FAIL flush_total got=%0d exp=%0d", o_flushed, mflush); end
    endtask

    task automatic test_fields();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc = 64'h300;
        i_instr = 32'h00C5_8533;
        cycle();
        i_valid = 1'b0;
        #1;
        n_cmp++;
        if (o_rs1_addr !== 5'd11 || o_rs2_addr !== 5'd12 || o_rd_addr !== 5'd10 || o_illegal !== 0) begin
            n_fail++;
            $display("FAIL fields got rs1=%0d rs2=%0d rd=%0d ill=%b exp 11 12 10 0", o_rs1_addr, o_rs2_addr, o_rd_addr, o_illegal);
        end
        i_valid = 1'b1;
        i_ready = 1'b1;
        i_pc = 64'h304;
        i_instr = 32'h0000_4501;
        cycle();
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        n_cmp++; if (o_illegal !== 1 || o_instr !== 32'h0000_4501) begin n_fail++; $display("FAIL illegal_head got ill=%b instr=%h exp 1 00004501", o_illegal, o_instr); end
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        n_cmp++; if (o_illegal !== 0 || o_valid !== 0) begin n_fail++; $display("FAIL illegal_empty got ill=%b valid=%b exp 0 0", o_illegal, o_valid); end
    endtask

    task automatic test_enable();
        logic [15:0] fl;
        i_valid = 1'b1;
        i_ready = 1'b0;
        i_instr = 32'h0000_0013;
        for (int k = 0; k < 2; k++) begin
            i_pc = 64'h700 + 64'(4 * k);
            cycle();
        end
        fl = o_flushed;
        enable = 1'b0;
        i_flush = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        n_cmp++; if (o_count !== 2)  begin n_fail++; $display("FAIL enable_count got=%0d exp=2", o_count); end
        n_cmp++; if (o_valid !== 0 || o_ready !== 0) begin n_fail++; $display("FAIL enable_hs got valid=%b ready=%b exp 0 0", o_valid, o_ready); end
        n_cmp++; if (o_flushed !== 16'(mflush) || o_flushed !== fl) begin n_fail++; $display("FAIL enable_flushed got=%0d exp=%0d", o_flushed, mflush); end
        enable = 1'b1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        #1;
        n_cmp++; if (o_pc !== 64'h700) begin n_fail++; $display("FAIL enable_head got=%h exp=700", o_pc); end
    endtask

    task automatic test_async_reset();
        do_reset();
        i_valid = 1'b1;
        i_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            i_pc = 64'h900 + 64'(4 * k);
            cycle();
        end
        i_valid = 1'b0;
        #2;
        reset = 1'b1;
        mq.delete();
        #1;
        n_cmp++;
        if (o_count !== 0 || o_empty !== 1 || o_valid !== 0 || o_ready !== 0 || o_flushed !== 0) begin
            n_fail++;
            $display("FAIL async_reset got count=%0d empty=%b valid=%b ready=%b flushed=%0d exp 0 1 0 0 0",
                     o_count, o_empty, o_valid, o_ready, o_flushed);
        end
        @(negedge clk);
        reset = 1'b0;
        cycle();
        n_cmp++; if (o_flushed !== 0 || o_ready !== 1) begin n_fail++; $display("FAIL async_after got flushed=%0d ready=%b exp 0 1", o_flushed, o_ready); end
    endtask

    task automatic test_random();
        logic [DW+IW-1:0] hd;
        bit ev, er, ei;
        for (int k = 0; k < 600; k++) begin
            enable  = ($urandom_range(0, 9) != 0);
            i_flush = ($urandom_range(0, 15) == 0);
            i_valid = $urandom_range(0, 1);
            i_ready = ($urandom_range(0, 2) != 0);
            i_pc    = {$urandom, $urandom};
            i_instr = $urandom;
            #1;
            ev = m_valid();
            er = m_ready();
            hd = (mq.size() > 0) ? mq[0] : '0;
            ei = ev && (hd[1:0] != 2'b11);
            n_cmp++;
            if (o_valid !== ev || o_ready !== er || o_illegal !== ei) begin
                n_fail++;
                $display("FAIL rand_hs k=%0d got v=%b r=%b ill=%b exp v=%b r=%b ill=%b", k, o_valid, o_ready, o_illegal, ev, er, ei);
            end
            if (mq.size() > 0) begin
                n_cmp++;
                if ({o_pc, o_instr} !== hd) begin
                    n_fail++;
                    $display("FAIL rand_head k=%0d got=%h exp=%h", k, {o_pc, o_instr}, hd);
                end
            end
            cycle();
            n_cmp++;
            if (o_count !== CW'(mq.size()) || o_full !== (mq.size() == DEPTH) ||
                o_empty !== (mq.size() == 0) || o_flushed !== 16'(mflush)) begin
                n_fail++;
                $display("FAIL rand_state k=%0d got count=%0d full=%b empty=%b fl=%0d exp count=%0d fl=%0d",
                         k, o_count, o_full, o_empty, o_flushed, mq.size(), mflush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_full_push_pop();
        test_streaming();
        test_flush();
        test_fields();
        test_enable();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
